// File: rtl/karatsuba_seq16.sv
// Sequential 16x16->32 unsigned multiplier that reuses one combinational 8x8
// Karatsuba core for the four byte products, accumulating them over four cycles.

module karatsuba_core8 (
    input  logic [7:0]  i_x,
    input  logic [7:0]  i_y,
    output logic [15:0] o_p
);
    logic [7:0]  w_z0;
    logic [7:0]  w_z2;
    logic [4:0]  w_sx;
    logic [4:0]  w_sy;
    logic [9:0]  w_z1_full;
    logic [9:0]  w_z1;

    assign w_z0      = i_x[3:0] * i_y[3:0];
    assign w_z2      = i_x[7:4] * i_y[7:4];
    assign w_sx      = {1'b0, i_x[3:0]} + {1'b0, i_x[7:4]};
    assign w_sy      = {1'b0, i_y[3:0]} + {1'b0, i_y[7:4]};
    assign w_z1_full = w_sx * w_sy;
    // Middle term xL*yH + xH*yL recovered from one product; never negative.
    assign w_z1      = w_z1_full - {2'b00, w_z2} - {2'b00, w_z0};
    assign o_p       = {w_z2, 8'h00} + {2'b00, w_z1, 4'h0} + {8'h00, w_z0};
endmodule

module karatsuba_seq16 #(
    parameter bit ZERO_SKIP = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      p,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid and its payload stay stable until that edge.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       r_step;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic [31:0]      r_acc;
    logic [31:0]      r_p;
    logic [CNT_W-1:0] r_op_count;

    logic [7:0]  w_core_x;
    logic [7:0]  w_core_y;
    logic [15:0] w_core_p;
    logic [31:0] w_addend;
    logic [31:0] w_sum;
    logic        w_zero;

    // Step bit 1 picks the high byte of a, step bit 0 the high byte of b.
    assign w_core_x = r_step[1] ? r_a[15:8] : r_a[7:0];
    assign w_core_y = r_step[0] ? r_b[15:8] : r_b[7:0];

    karatsuba_core8 u_core (
        .i_x (w_core_x),
        .i_y (w_core_y),
        .o_p (w_core_p)
    );

    always_comb begin
        w_addend = 32'h0;
        case (r_step)
            2'd0:    w_addend = {16'h0000, w_core_p};
            2'd1,
            2'd2:    w_addend = {8'h00, w_core_p, 8'h00};
            default: w_addend = {w_core_p, 16'h0000};
        endcase
    end

    assign w_sum  = r_acc + w_addend;
    assign w_zero = ZERO_SKIP && ((r_a == 16'h0) || (r_b == 16'h0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_step     <= 2'd0;
            r_a        <= 16'h0;
            r_b        <= 16'h0;
            r_acc      <= 32'h0;
            r_p        <= 32'h0;
            r_op_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= 32'h0;
                        r_step  <= 2'd0;
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    // Zero operand is detected on the first MUL edge, so the
                    // short path still spends exactly one cycle.
                    if ((r_step == 2'd0) && w_zero) begin
                        r_acc   <= 32'h0;
                        r_p     <= 32'h0;
                        r_state <= ST_DONE;
                    end else begin
                        r_acc  <= w_sum;
                        r_step <= r_step + 2'd1;
                        if (r_step == 2'd3) begin
                            r_p     <= w_sum;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_op_count <= r_op_count + CNT_ONE;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign p         = r_p;
    assign op_count  = r_op_count;
    assign dbg_state = r_state;
endmodule
